// File: rtl/axil_reg_sequencer.sv
// AXI4-Lite self-test master: writes NUM_REGS words (seed+i), reads them back and reports pass/fail.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module axil_reg_sequencer #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          start,
   input  logic [31:0]                   seed,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [4:0]                    err_count,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [31:0]                   M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [31:0]                   M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_width
      $error("axil_reg_sequencer supports only 32-bit data");
   end

   localparam int            IW   = 4;
   localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

   state_t        state, state_nx;
   logic [31:0]   seed_q, seed_nx;
   logic [IW-1:0] idx, idx_nx;
   logic          aw_done, aw_done_nx, w_done, w_done_nx;
   logic          error_nx;
   logic [4:0]    cnt_nx;
   logic [31:0]   exp_data;
   logic          aw_hs, w_hs;
`ifdef SEQ_TIMEOUT_EN
   logic [7:0]    wd_q, wd_nx;
   logic          hs_any;
`endif

   function automatic logic [4:0] sat_inc(input logic [4:0] c);
      return (c == 5'd31) ? c : c + 5'd1;
   endfunction

   // VALID/READY are decoded from registered state, so async reset drops them at once
   assign M_AXI_AWVALID = (state == S_WADDR) && !aw_done;
   assign M_AXI_WVALID  = (state == S_WADDR) && !w_done;
   assign M_AXI_BREADY  = (state == S_WRESP);
   assign M_AXI_ARVALID = (state == S_RADDR);
   assign M_AXI_RREADY  = (state == S_RDATA);
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_AWADDR  = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx) << 2);
   assign M_AXI_ARADDR  = M_AXI_AWADDR;
   assign exp_data      = seed_q + 32'(idx);
   assign M_AXI_WDATA   = exp_data;
   assign busy          = (state != S_IDLE) && (state != S_DONE);
   assign done          = (state == S_DONE);
   assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= S_IDLE;
         seed_q    <= '0;
         idx       <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         error     <= 1'b0;
         err_count <= '0;
`ifdef SEQ_TIMEOUT_EN
         wd_q      <= '0;
`endif
      end else begin
         state     <= state_nx;
         seed_q    <= seed_nx;
         idx       <= idx_nx;
         aw_done   <= aw_done_nx;
         w_done    <= w_done_nx;
         error     <= error_nx;
         err_count <= cnt_nx;
`ifdef SEQ_TIMEOUT_EN
         wd_q      <= wd_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      seed_nx    = seed_q;
      idx_nx     = idx;
      aw_done_nx = aw_done;
      w_done_nx  = w_done;
      error_nx   = error;
      cnt_nx     = err_count;
      case (state)
         S_IDLE: if (start) begin
            seed_nx    = seed;
            idx_nx     = '0;
            error_nx   = 1'b0;
            cnt_nx     = '0;
            aw_done_nx = 1'b0;
            w_done_nx  = 1'b0;
            state_nx   = S_WADDR;
         end
         S_WADDR: begin
            // AW and W complete independently; leave only once both have
            if (aw_hs) aw_done_nx = 1'b1;
            if (w_hs)  w_done_nx  = 1'b1;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               aw_done_nx = 1'b0;
               w_done_nx  = 1'b0;
               state_nx   = S_WRESP;
            end
         end
         S_WRESP: if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) begin
               error_nx = 1'b1;
               cnt_nx   = sat_inc(err_count);
            end
            if (idx == LAST) begin
               idx_nx   = '0;
               state_nx = S_RADDR;
            end else begin
               idx_nx   = idx + 1'b1;
               state_nx = S_WADDR;
            end
         end
         S_RADDR: if (M_AXI_ARREADY) state_nx = S_RDATA;
         S_RDATA: if (M_AXI_RVALID) begin
            if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != exp_data) begin
               error_nx = 1'b1;
               cnt_nx   = sat_inc(err_count);
            end
            if (idx == LAST) begin
               state_nx = S_DONE;
            end else begin
               idx_nx   = idx + 1'b1;
               state_nx = S_RADDR;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
`ifdef SEQ_TIMEOUT_EN
      // watchdog counts consecutive wait cycles between handshakes
      hs_any = aw_hs || w_hs || (M_AXI_BVALID && M_AXI_BREADY) ||
               (M_AXI_ARVALID && M_AXI_ARREADY) || (M_AXI_RVALID && M_AXI_RREADY);
      wd_nx  = (busy && !hs_any) ? wd_q + 8'd1 : 8'd0;
      if (wd_q == 8'hFF) begin
         error_nx   = 1'b1;
         cnt_nx     = 5'd31;
         idx_nx     = '0;
         aw_done_nx = 1'b0;
         w_done_nx  = 1'b0;
         wd_nx      = 8'd0;
         state_nx   = S_DONE;
      end
`endif
   end

endmodule

// File: doc/axil_reg_sequencer.md
Name: axil_reg_sequencer

Overview:
- AXI4-Lite master that self-tests the 4-register pass peripheral.
- On `start`, writes NUM_REGS words at consecutive word addresses, reads each back, compares, and reports pass/fail.
- Sits in the block design in place of the verification master and drives the peripheral's S00_AXI port directly.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- NUM_REGS, 4, number of registers exercised; range 1..16.
- BASE_ADDR, 0, byte address of register 0.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- seed  in  32  data written to register 0; sampled when start is accepted.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence.
- error  out  1  sticky; set on any failure, cleared on the next accepted start.
- err_count  out  5  number of failed checks, saturating at 31.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 0.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 0.
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0; busy, done, error 0; err_count 0; index 0; state IDLE. Reset is asynchronous, so a mid-transfer reset drops VALIDs immediately. The peripheral shares ARESETN, so this is permitted.
- Register i: address = BASE_ADDR + 4*i, truncated to C_M_AXI_ADDR_WIDTH (wraps modulo 2^width). Data = seed + i, modulo 2^32.
- State IDLE:
  - start=1 → latch seed, index=0, clear error/err_count, busy=1, go to WADDR.
  - Accept-to-AWVALID latency is 1 cycle.
- State WADDR:
  - AWVALID and WVALID rise in the same cycle.
  - Each drops in the cycle after its own handshake. AW and W may complete in either order or together.
  - When both have completed → WRESP.
  - AWADDR/WDATA are held stable while their VALID is high.
- State WRESP:
  - BREADY=1.
  - On BVALID: BRESP≠OKAY → error=1, err_count+1.
  - If index=NUM_REGS-1 → index=0, go to RADDR; else index+1, go to WADDR.
- State RADDR: ARVALID=1 until ARREADY, then → RDATA.
- State RDATA:
  - RREADY=1.
  - On RVALID: failure if RRESP≠OKAY or RDATA≠seed+index → error=1, err_count+1 (saturating at 31).
  - Last index → DONE; else index+1, go to RADDR.
- State DONE:
  - done=1 for one cycle, busy=0 in that same cycle, → IDLE.
  - start asserted in the DONE cycle is ignored.
- Only one transaction is outstanding at a time. No read is issued before the last B is received.
- error/err_count hold their values until the next accepted start.
- Same-cycle VALID+READY counts as a handshake, including when VALID and READY are both already high on VALID's first cycle.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent waiting in WADDR, WRESP, RADDR or RDATA; it resets on every handshake.
  - Reaching 255 → error=1, err_count=31, all VALID/READY deasserted, → DONE.
- Undefined: no watchdog; the sequencer waits indefinitely. No ports differ.

Test Plan:
- Ready-always slave, seed=32'h00000001, NUM_REGS=4:
  - writes 1,2,3,4 to 0x0/0x4/0x8/0xC;
  - reads match; done pulses once; error=0, err_count=0.
- Slave returns RDATA bit 31 flipped on address 0x8 → error=1, err_count=1, done still pulses.
- Back-pressure:
  - WREADY delayed 3 cycles after AWREADY, then AWREADY delayed 2 cycles after WREADY;
  - each VALID held until its own handshake; no duplicate beats; data correct.
- BRESP=SLVERR on the first write only → err_count=1; all readbacks still pass.
- Reset asserted during RDATA of index 2 → all outputs return to reset values within the same cycle. A new start then completes with err_count=0.
- With SEQ_TIMEOUT_EN: ARREADY held at 0 → after 255 cycles error=1, err_count=31, done pulses, ARVALID=0.
